// File: rtl/mul_arbiter_pkg.sv
// Shared types and sizing helpers for the multiplier arbiter.
package mul_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  // Width of a requester pointer; a single bit is kept for the two-requester case.
  function automatic int ptr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int DEFAULT_N_REQ = 4;
  localparam int PTR_W         = ptr_width(DEFAULT_N_REQ);

endpackage

// File: rtl/mul_arbiter_rr_picker.sv
// Combinational round-robin search: first active request after ptr, with wrap.
module rr_picker
  import mul_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = ptr_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] winner,
  output logic [PW-1:0]    index,
  output logic             found
);

  logic [PW-1:0] cand;

  // Walk ptr+1, ptr+2, ... around the ring and keep the first hit.
  always_comb begin
    winner = '0;
    index  = '0;
    found  = 1'b0;
    cand   = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = PW'((int'(ptr) + off) % N_REQ);
      if (!found && req[cand]) begin
        found         = 1'b1;
        winner[cand]  = 1'b1;
        index         = cand;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin front end sharing one external multi-cycle multiplier among N_REQ requesters.
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int C_WIDTH = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                     ctl_clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*C_WIDTH-1:0] a_in,
  input  logic [N_REQ*C_WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         err,
  output logic [C_WIDTH-1:0]       y_out,
  output logic                     busy,
  output logic [C_WIDTH-1:0]       mul_a,
  output logic [C_WIDTH-1:0]       mul_b,
  output logic                     mul_trigger,
  input  logic                     mul_ready,
  input  logic                     mul_done,
  input  logic [C_WIDTH-1:0]       mul_y
);

  localparam int PW = ptr_width(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    index;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic [N_REQ-1:0] index_onehot;
  logic [N_REQ-1:0] win;
  logic [PW-1:0]    win_index;
  logic             win_found;

  rr_picker #(
    .N_REQ(N_REQ),
    .PW   (PW)
  ) u_picker (
    .req   (req),
    .ptr   (ptr),
    .winner(win),
    .index (win_index),
    .found (win_found)
  );

  assign index_onehot = N_REQ'(1) << index;
  assign cnt_next     = (cnt == '1) ? cnt : cnt + 1'b1;

  // Arbitration, multiplier handshake and timeout supervision with registered outputs.
  always_ff @(posedge ctl_clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= PW'(N_REQ - 1);
      index       <= '0;
      cnt         <= '0;
      gnt         <= '0;
      done        <= '0;
      err         <= '0;
      mul_trigger <= 1'b0;
      busy        <= 1'b0;
      y_out       <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      err  <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt         <= win;
            index       <= win_index;
            mul_a       <= a_in[int'(win_index)*C_WIDTH +: C_WIDTH];
            mul_b       <= b_in[int'(win_index)*C_WIDTH +: C_WIDTH];
            cnt         <= '0;
            mul_trigger <= 1'b1;
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (cnt == LAST_CNT) begin
            err         <= index_onehot;
            ptr         <= index;
            mul_trigger <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt_next;
            if (mul_ready) begin
              mul_trigger <= 1'b0;
              state       <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mul_done) begin
            y_out <= mul_y;
            done  <= index_onehot;
            state <= RESP;
          end else if (cnt == LAST_CNT) begin
            err   <= index_onehot;
            ptr   <= index;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt_next;
          end
        end
        RESP: begin
          ptr   <= index;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter C_WIDTH, default 32, meaning the operand and result width.
REQ-003 The block SHALL have parameter TIMEOUT, default 64, meaning the maximum cycles to wait for mul_done.
REQ-004 The block SHALL have port ctl_clk  in  1  clock; all logic rising-edge.
REQ-005 The block SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port req  in  N_REQ  per-requester request level.
REQ-007 The block SHALL have ports a_in and b_in  in  N_REQ*C_WIDTH  operands; requester i occupies slice [i*C_WIDTH +: C_WIDTH].
REQ-008 The block SHALL have port gnt  out  N_REQ  one-hot, one-cycle pulse when the winner's operands are sampled.
REQ-009 The block SHALL have port done  out  N_REQ  one-hot, one-cycle pulse when y_out is valid for that requester.
REQ-010 The block SHALL have port err  out  N_REQ  one-hot, one-cycle pulse on timeout for that requester.
REQ-011 The block SHALL have port y_out  out  C_WIDTH  last result, passed through from mul_y unmodified.
REQ-012 The block SHALL have port busy  out  1  high in any state other than IDLE.
REQ-013 The block SHALL have ports mul_a and mul_b  out  C_WIDTH  operands to the shared multi-cycle multiplier.
REQ-014 The block SHALL have ports mul_trigger  out  1  and mul_ready, mul_done  in  1  multiplier handshake.
REQ-015 The block SHALL have port mul_y  in  C_WIDTH  multiplier result, already fixed-point scaled.

Function
REQ-016 The state machine SHALL have exactly four states: IDLE, ISSUE, WAIT and RESP.
REQ-017 In IDLE with any req bit high, the block SHALL grant round-robin, searching from ptr+1 upward with wrap; it SHALL pulse gnt, latch that requester's a_in/b_in and index, and go to ISSUE in the same cycle.
REQ-018 In ISSUE the block SHALL hold mul_trigger=1 with latched mul_a/mul_b stable; on a cycle sampling mul_ready=1 it SHALL go to WAIT and drop mul_trigger on the next cycle.
REQ-019 In WAIT, on mul_done=1 the block SHALL capture mul_y into y_out and go to RESP.
REQ-020 In RESP the block SHALL pulse done[index] for one cycle, set ptr=index, and return to IDLE.
REQ-021 Arbitration latency SHALL be: a single req with IDLE gives gnt in the same cycle; done appears at least 3 cycles after gnt.
REQ-022 No new grant SHALL occur in states other than IDLE; back-to-back operations SHALL have one IDLE cycle between RESP and the next gnt.
REQ-023 A timeout counter SHALL clear on entry to ISSUE, run through ISSUE and WAIT, and saturate.
REQ-024 When the counter reaches TIMEOUT-1, the block SHALL pulse err[index], leave y_out unchanged, set ptr=index, and go to IDLE with no done pulse.
REQ-025 mul_done seen in ISSUE SHALL be ignored.
REQ-026 A req drop after gnt SHALL be ignored: the operation completes and done still pulses.
REQ-027 A req drop before gnt SHALL mean that requester is not granted.
REQ-028 All of req high simultaneously SHALL give each requester exactly one grant per N_REQ operations.
REQ-029 The block SHALL add no arithmetic; y_out is C_WIDTH bits, taken verbatim from mul_y.

Reset
REQ-030 With reset high at a rising edge, the state machine SHALL go to IDLE, ptr = N_REQ-1 (first grant favours requester 0), and the timeout counter, gnt, done, err, mul_trigger, busy, y_out, mul_a and mul_b SHALL all be 0.
REQ-031 Reset mid-operation SHALL abort with no done or err pulse; a late mul_done afterwards SHALL be ignored in IDLE.

Structure
REQ-032 A shared package SHALL hold the state enumeration (IDLE, ISSUE, WAIT, RESP) and the ptr width constant clog2(N_REQ).
REQ-033 One sub-module, rr_picker, SHALL be combinational: it takes req and ptr and returns a one-hot winner and its index.
REQ-034 The multiplier SHALL remain outside mul_arbiter and connect through the mul_* ports.

Verification
REQ-035 Single request: req=4'b0001, a=0x0000_0300, b=0x0000_0200, model multiplier returns 0x600 after 33 cycles -> gnt[0] at cycle 0; done[0] 1 cycle after mul_done; y_out=0x600.
REQ-036 Round-robin fairness: req=4'b1111 held for 8 operations -> grant order 0,1,2,3,0,1,2,3.
REQ-037 Requester drops early: req=4'b0110 after an operation by requester 1, requester 2 drops req in the WAIT state of that operation -> it is not granted; the next grant goes to requester 1.
REQ-038 Timeout: model never asserts mul_done, TIMEOUT=64 -> err[index] exactly 64 cycles after ISSUE entry; no done pulse; back to IDLE; the next request is granted.
REQ-039 Ready stall: mul_ready held low for 10 cycles in ISSUE -> mul_trigger stays high and mul_a/mul_b stay stable; WAIT is entered on the first cycle with mul_ready=1.
REQ-040 Reset mid-WAIT: assert reset in WAIT, then the model pulses mul_done -> all outputs are 0, state is IDLE, and there is no done pulse.
